// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_types_pkg
// Brief   : Shared CPU types and default instruction-cache geometry.
// Revision: 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_t;

  localparam int ICACHE_SETS        = 16;
  localparam int ICACHE_BLOCK_WORDS = 2;

endpackage
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module  : icache_dm
// Brief   : Direct-mapped, read-only instruction cache with line refill FSM.
// Revision: 1.0
// ============================================================================
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int SETS        = ICACHE_SETS,
  parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  inval,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int c_off_w = $clog2(BLOCK_WORDS);
  localparam int c_cnt_w = (c_off_w > 0) ? c_off_w : 1;
  localparam int c_idx_w = $clog2(SETS);
  localparam int c_tag_w = 30 - c_off_w - c_idx_w;
  localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(BLOCK_WORDS - 1);

  logic [c_tag_w-1:0] w_tag;
  logic [c_idx_w-1:0] w_idx;
  logic [c_cnt_w-1:0] w_off;
  logic [1:0]         w_unused_byte;

  logic [SETS-1:0]    r_valid;
  logic [c_tag_w-1:0] r_tags [SETS];
  word_t              r_data [SETS][BLOCK_WORDS];

  icache_state_t      r_state;
  logic [c_tag_w-1:0] r_fill_tag;
  logic [c_idx_w-1:0] r_fill_idx;
  logic [c_cnt_w-1:0] r_cnt;
  word_t              r_hit_count;
  word_t              r_miss_count;
  word_t              r_last;

  word_t w_lookup;
  word_t w_fill_addr;
  logic  w_hit;
  logic  w_fill_wr;

  assign w_tag         = imemaddr[31 -: c_tag_w];
  assign w_idx         = imemaddr[2 + c_off_w +: c_idx_w];
  assign w_unused_byte = imemaddr[1:0];

  generate
    if (c_off_w > 0) begin : g_word_off
      assign w_off = imemaddr[2 +: c_cnt_w];
    end else begin : g_single_word
      assign w_off = '0;
    end
  endgenerate

  always_comb begin
    w_lookup    = r_data[w_idx][w_off];
    w_hit       = !RST && (r_state == ICACHE_IDLE) && imemREN &&
                  r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    w_fill_addr = (word_t'({r_fill_tag, r_fill_idx, 2'b00}) << c_off_w) |
                  (word_t'(r_cnt) << 2);
    // Invalidate wins over the final handshake, so the abandoned line is never written.
    w_fill_wr   = !RST && (r_state == ICACHE_FILL) && !inval && !iwait;
  end

  assign ihit       = w_hit;
  assign imemload   = w_hit ? w_lookup : r_last;
  assign iREN       = !RST && (r_state == ICACHE_FILL);
  assign iaddr      = iREN ? w_fill_addr : '0;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ICACHE_IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_last       <= '0;
    end else begin
      case (r_state)
        ICACHE_IDLE: begin
          if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
            r_last      <= w_lookup;
          end else if (imemREN) begin
            r_fill_tag   <= w_tag;
            r_fill_idx   <= w_idx;
            r_cnt        <= '0;
            r_miss_count <= r_miss_count + 32'd1;
            r_state      <= ICACHE_FILL;
          end
          if (inval) begin
            r_valid <= '0;
          end
        end
        ICACHE_FILL: begin
          if (inval) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_state <= ICACHE_IDLE;
          end else if (!iwait) begin
            if (r_cnt == c_last_word) begin
              r_valid[r_fill_idx] <= 1'b1;
              r_cnt               <= '0;
              r_state             <= ICACHE_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ICACHE_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (w_fill_wr) begin
      r_data[r_fill_idx][r_cnt] <= iload;
      if (r_cnt == c_last_word) begin
        r_tags[r_fill_idx] <= r_fill_tag;
      end
    end
  end

endmodule
`default_nettype wire
